// File: rtl/deal_sequencer.sv
// -----------------------------------------------------------------------------
// deal_sequencer
//
// Round controller for the baccarat datapath. Deals one card per slow_clock
// cycle (player, banker, player, banker), pulses the matching card-register
// load enable, then applies the natural / player-draw / banker-draw rules
// using the totals from the two downstream hand scorers. The winner lights
// are registered on the S_SCORE exit edge and held until reset.
//
// Build option:
//   BANKER_TABLEAU_EN  defined   -> S_BANK uses the full third-card table
//                                   (dscore together with the player's third
//                                   card value).
//                      undefined -> S_BANK ignores pcard3; banker draws iff
//                                   dscore <= 5.
//
// Ports:
//   slow_clock        in   sole clock, rising edge active
//   reset             in   synchronous, active-high; returns to S_IDLE
//   pscore[3:0]       in   player total (0-9)
//   dscore[3:0]       in   banker total (0-9)
//   pcard3[3:0]       in   player third card raw code (1-13, 10-13 count 0)
//   load_pcard1..3    out  player card register load enables
//   load_dcard1..3    out  banker card register load enables
//   player_win_light  out  registered; player won or tie
//   dealer_win_light  out  registered; banker won or tie
//   round_done        out  high while in S_DONE
// -----------------------------------------------------------------------------
module deal_sequencer (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_P1    = 4'd1,
        S_D1    = 4'd2,
        S_P2    = 4'd3,
        S_D2    = 4'd4,
        S_EVAL  = 4'd5,
        S_P3    = 4'd6,
        S_BANK  = 4'd7,
        S_D3    = 4'd8,
        S_SCORE = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic   r_player_win;
    logic   r_dealer_win;
    logic   w_natural;
    logic   w_bank_draw;

    // Either hand totalling 8 or 9 after two cards ends the round at once.
    assign w_natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                       (dscore == 4'd8) || (dscore == 4'd9);

`ifdef BANKER_TABLEAU_EN
    // Banker third-card table; face cards and tens (10-13) count as zero.
    function automatic logic tableau_draw(input logic [3:0] d, input logic [3:0] pc3);
        logic [3:0] v;
        logic       draw;
        v    = (pc3 <= 4'd9) ? pc3 : 4'd0;
        draw = 1'b0;
        case (d)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    assign w_bank_draw = tableau_draw(dscore, pcard3);
`else
    logic w_unused_pcard3;

    // Simplified banker rule: the player's third card plays no part.
    assign w_bank_draw     = (dscore <= 4'd5);
    assign w_unused_pcard3 = ^pcard3;
`endif

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Lights change only when leaving S_SCORE; S_DONE holds them.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else if (r_state == S_SCORE) begin
            r_player_win <= (pscore >= dscore);
            r_dealer_win <= (dscore >= pscore);
        end
    end

    always_comb begin
        w_next      = S_IDLE;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        round_done  = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_P1;
            S_P1: begin
                load_pcard1 = 1'b1;
                w_next      = S_D1;
            end
            S_D1: begin
                load_dcard1 = 1'b1;
                w_next      = S_P2;
            end
            S_P2: begin
                load_pcard2 = 1'b1;
                w_next      = S_D2;
            end
            S_D2: begin
                load_dcard2 = 1'b1;
                w_next      = S_EVAL;
            end
            S_EVAL: begin
                if (w_natural) begin
                    w_next = S_SCORE;
                end else if (pscore <= 4'd5) begin
                    w_next = S_P3;
                end else if (dscore <= 4'd5) begin
                    w_next = S_D3;
                end else begin
                    w_next = S_SCORE;
                end
            end
            S_P3: begin
                load_pcard3 = 1'b1;
                w_next      = S_BANK;
            end
            S_BANK: w_next = w_bank_draw ? S_D3 : S_SCORE;
            S_D3: begin
                load_dcard3 = 1'b1;
                w_next      = S_SCORE;
            end
            S_SCORE: w_next = S_DONE;
            S_DONE: begin
                round_done = 1'b1;
                w_next     = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign player_win_light = r_player_win;
    assign dealer_win_light = r_dealer_win;

endmodule

// File: tb/tb_deal_sequencer.sv
// -----------------------------------------------------------------------------
// tb_deal_sequencer
//
// Directed bench for deal_sequencer. Each scenario task plays a round with
// hand-picked scores, logs the loads, lights and round_done per cycle
// (cycle 0 = first S_IDLE cycle after reset release) and compares them with
// the expected per-cycle timeline. Build-dependent expectations follow
// BANKER_TABLEAU_EN.
// -----------------------------------------------------------------------------
module tb_deal_sequencer;

    logic       slow_clock;
    logic       reset;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, round_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] ld_log [0:14];
    logic [2:0] lt_log [0:14];

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    function automatic logic [5:0] ld_vec();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    endfunction

    // Expected load vector {p1,d1,p2,d2,p3,d3} at cycle c.
    function automatic logic [5:0] exp_ld(input int c, input int p3c, input int d3c);
        logic [5:0] e;
        case (c)
            1:       e = 6'b100000;
            2:       e = 6'b010000;
            3:       e = 6'b001000;
            4:       e = 6'b000100;
            default: e = 6'b000000;
        endcase
        if (c == p3c) e = 6'b000010;
        if (c == d3c) e = 6'b000001;
        return e;
    endfunction

    // Plays one round from reset; scores switch to pb/db just after cycle chg.
    task automatic run_round(input logic [3:0] pa, input logic [3:0] da, input logic [3:0] pc,
                             input int chg, input logic [3:0] pb, input logic [3:0] db);
        pscore = pa;
        dscore = da;
        pcard3 = pc;
        reset  = 1'b1;
        @(posedge slow_clock);
        #1;
        reset     = 1'b0;
        ld_log[0] = ld_vec();
        lt_log[0] = {player_win_light, dealer_win_light, round_done};
        for (int c = 1; c <= 14; c++) begin
            @(posedge slow_clock);
            #1;
            ld_log[c] = ld_vec();
            lt_log[c] = {player_win_light, dealer_win_light, round_done};
            if (c == chg) begin
                pscore = pb;
                dscore = db;
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd1;
        repeat (2) @(posedge slow_clock);
        #1;
        n_cmp++;
        if ({ld_vec(), player_win_light, dealer_win_light, round_done} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b",
                     {ld_vec(), player_win_light, dealer_win_light, round_done}, 9'b0);
        end
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge slow_clock);
            #1;
        end
        n_cmp++;
        if (ld_vec() !== 6'b001000) begin
            n_fail++;
            $display("FAIL reset_pre_p2: got %b want %b", ld_vec(), 6'b001000);
        end
        reset = 1'b1;
        @(posedge slow_clock);
        #1;
        n_cmp++;
        if ({ld_vec(), player_win_light, dealer_win_light, round_done} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_mid_deal: got %b want %b",
                     {ld_vec(), player_win_light, dealer_win_light, round_done}, 9'b0);
        end
        reset = 1'b0;
        @(posedge slow_clock);
        #1;
        n_cmp++;
        if (ld_vec() !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_restart_p1: got %b want %b", ld_vec(), 6'b100000);
        end
    endtask

    task automatic test_natural;
        // Player natural 8 beats 3: no third cards, lights from cycle 7.
        run_round(4'd8, 4'd3, 4'd1, -1, 4'd8, 4'd3);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, -1, -1)) begin
                n_fail++;
                $display("FAIL natural_loads cyc %0d: got %b want %b", c, ld_log[c], exp_ld(c, -1, -1));
            end
            n_cmp++;
            if (lt_log[c] !== ((c >= 7) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL natural_lights cyc %0d: got %b want %b", c, lt_log[c],
                         (c >= 7) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_both_stand;
        // 7/7: nobody draws, tie lights both from cycle 7.
        run_round(4'd7, 4'd7, 4'd1, -1, 4'd7, 4'd7);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, -1, -1) || lt_log[c] !== ((c >= 7) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL both_stand cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, -1, -1), (c >= 7) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_player_stands_banker_draws;
        // 6/4 at S_EVAL -> S_D3 at 6; scores become 6/6 for S_SCORE -> tie at 8.
        run_round(4'd6, 4'd4, 4'd1, 6, 4'd6, 4'd6);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, -1, 6)) begin
                n_fail++;
                $display("FAIL pstand_loads cyc %0d: got %b want %b", c, ld_log[c], exp_ld(c, -1, 6));
            end
            n_cmp++;
            if (lt_log[c] !== ((c >= 8) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL pstand_lights cyc %0d: got %b want %b", c, lt_log[c],
                         (c >= 8) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_player_draw_face;
        int d3c;
        int ltc;
        // 2/4, pcard3=12 (value 0): table says stand, simple rule says draw.
`ifdef BANKER_TABLEAU_EN
        d3c = -1;
        ltc = 9;
`else
        d3c = 8;
        ltc = 10;
`endif
        run_round(4'd2, 4'd4, 4'd12, -1, 4'd2, 4'd4);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, d3c)) begin
                n_fail++;
                $display("FAIL pdraw_face_loads cyc %0d: got %b want %b", c, ld_log[c], exp_ld(c, 6, d3c));
            end
            n_cmp++;
            if (lt_log[c] !== ((c >= ltc) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL pdraw_face_lights cyc %0d: got %b want %b", c, lt_log[c],
                         (c >= ltc) ? 3'b011 : 3'b000);
            end
        end
    endtask

    task automatic test_banker_tableau;
        // 2/4 with pcard3=5: banker draws in both builds; 7 vs 9 at S_SCORE.
        run_round(4'd2, 4'd4, 4'd5, 8, 4'd7, 4'd9);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, 8) || lt_log[c] !== ((c >= 10) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL tableau_draw cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, 6, 8), (c >= 10) ? 3'b011 : 3'b000);
            end
        end
    endtask

    task automatic test_config;
        int d3c;
        int ltc;
        int d3b;
        int ltb;
        // 3/6 with pcard3=6: table draws, simple rule stands.
        // 5/3 with pcard3=8: table stands, simple rule draws.
`ifdef BANKER_TABLEAU_EN
        d3c = 8;  ltc = 10;
        d3b = -1; ltb = 9;
`else
        d3c = -1; ltc = 9;
        d3b = 8;  ltb = 10;
`endif
        run_round(4'd3, 4'd6, 4'd6, -1, 4'd3, 4'd6);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, d3c) || lt_log[c] !== ((c >= ltc) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL config_d6 cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, 6, d3c), (c >= ltc) ? 3'b011 : 3'b000);
            end
        end
        run_round(4'd5, 4'd3, 4'd8, -1, 4'd5, 4'd3);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, d3b) || lt_log[c] !== ((c >= ltb) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL config_d3v8 cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, 6, d3b), (c >= ltb) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_bank_boundaries;
        // Banker 7 always stands after the player draws: 4 vs 7, lights at 9.
        run_round(4'd4, 4'd7, 4'd6, -1, 4'd4, 4'd7);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, -1) || lt_log[c] !== ((c >= 9) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL bank_seven cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, 6, -1), (c >= 9) ? 3'b011 : 3'b000);
            end
        end
        // Banker 0 always draws, even against an 8: 0/0 tie, lights at 10.
        run_round(4'd0, 4'd0, 4'd8, -1, 4'd0, 4'd0);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, 6, 8) || lt_log[c] !== ((c >= 10) ? 3'b111 : 3'b000)) begin
                n_fail++;
                $display("FAIL bank_zero cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, 6, 8), (c >= 10) ? 3'b111 : 3'b000);
            end
        end
    endtask

    task automatic test_back_to_back;
        // Player natural 9 vs 2; scores flip while in S_DONE and lights must hold.
        run_round(4'd9, 4'd2, 4'd1, 8, 4'd0, 4'd9);
        for (int c = 7; c <= 14; c++) begin
            n_cmp++;
            if (lt_log[c] !== 3'b101) begin
                n_fail++;
                $display("FAIL done_hold cyc %0d: got %b want %b", c, lt_log[c], 3'b101);
            end
        end
        reset = 1'b1;
        @(posedge slow_clock);
        #1;
        n_cmp++;
        if ({ld_vec(), player_win_light, dealer_win_light, round_done} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_from_done: got %b want %b",
                     {ld_vec(), player_win_light, dealer_win_light, round_done}, 9'b0);
        end
        // Banker natural 8 vs 1 straight after.
        run_round(4'd1, 4'd8, 4'd1, -1, 4'd1, 4'd8);
        for (int c = 0; c <= 14; c++) begin
            n_cmp++;
            if (ld_log[c] !== exp_ld(c, -1, -1) || lt_log[c] !== ((c >= 7) ? 3'b011 : 3'b000)) begin
                n_fail++;
                $display("FAIL second_round cyc %0d: got %b/%b want %b/%b", c, ld_log[c], lt_log[c],
                         exp_ld(c, -1, -1), (c >= 7) ? 3'b011 : 3'b000);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        test_reset();
        test_natural();
        test_both_stand();
        test_player_stands_banker_draws();
        test_player_draw_face();
        test_banker_tableau();
        test_config();
        test_bank_boundaries();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
